// File: rtl/fxp_div_pkg.sv
// rtl/fxp_div_pkg.sv - shared encodings and sign-magnitude helpers for fxp_div_seq
package fxp_div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter must reach N-1+Q, the final formatting step after the last quotient bit.
    function automatic int cnt_width(input int n, input int q);
        return $clog2(n + q);
    endfunction

    function automatic logic sm_sign(input logic [63:0] v, input int n);
        return v[n-1];
    endfunction

    function automatic logic [63:0] sm_mag(input logic [63:0] v, input int n);
        return v & ((64'd1 << (n - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/fxp_div_seq.sv
// rtl/fxp_div_seq.sv - multi-cycle radix-2 restoring divider for sign-magnitude fixed point
module fxp_div_seq
    import fxp_div_pkg::*;
#(
    parameter int N        = 20,
    parameter int Q        = 15,
    parameter int SATURATE = 1,
    parameter int TAG_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_dividend,
    input  logic [N-1:0]     i_divisor,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_quotient,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_overflow,
    output logic             o_div_by_zero,
    output logic             o_busy
);

    localparam int M     = N - 1;
    localparam int ITER  = N - 1 + Q;
    localparam int CNT_W = cnt_width(N, Q);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ITER-1:0]  dq;
    logic [N-1:0]     rem;
    logic [M-1:0]     dvsr;
    logic [CNT_W-1:0] cnt;
    logic             sign;
    logic [TAG_W-1:0] tag_r;
    logic [N-1:0]     quot_r;
    logic             ovf_r;
    logic             dbz_r;

    logic             accept;
    logic             sign_in;
    logic [M-1:0]     mag_a;
    logic [M-1:0]     mag_b;
    logic             div_zero;
    logic             last_step;
    logic [N-1:0]     rem_sh;
    logic [N:0]       diff;
    logic             q_bit;
    logic [N-1:0]     rem_nxt;
    logic             ovf_calc;
    logic [M-1:0]     mag_out;

    assign o_ready       = (state == S_IDLE);
    assign o_busy        = (state != S_IDLE);
    assign o_valid       = (state == S_DONE);
    assign o_quotient    = quot_r;
    assign o_tag         = tag_r;
    assign o_overflow    = ovf_r;
    assign o_div_by_zero = dbz_r;

    assign accept    = i_valid && o_ready;
    assign sign_in   = sm_sign(64'(i_dividend), N) ^ sm_sign(64'(i_divisor), N);
    assign mag_a     = M'(sm_mag(64'(i_dividend), N));
    assign mag_b     = M'(sm_mag(64'(i_divisor), N));
    assign div_zero  = (mag_b == '0);
    assign last_step = (cnt == CNT_W'(ITER));

    // Restoring step: bring in the next dividend bit, keep the difference only if it did not borrow.
    assign rem_sh  = {rem[N-2:0], dq[ITER-1]};
    assign diff    = {1'b0, rem_sh} - {2'b00, dvsr};
    assign q_bit   = ~diff[N];
    assign rem_nxt = q_bit ? diff[N-1:0] : rem_sh;

    assign ovf_calc = |dq[ITER-1 -: Q];
    assign mag_out  = (ovf_calc && (SATURATE != 0)) ? '1 : dq[M-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = div_zero ? S_DONE : S_CALC;
            S_CALC: if (last_step) state_nxt = S_DONE;
            S_DONE: if (i_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dq     <= '0;
            rem    <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            sign   <= 1'b0;
            tag_r  <= '0;
            quot_r <= '0;
            ovf_r  <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sign  <= sign_in;
                        dq    <= {mag_a, {Q{1'b0}}};
                        dvsr  <= mag_b;
                        rem   <= '0;
                        cnt   <= '0;
                        tag_r <= i_tag;
                        dbz_r <= div_zero;
                        ovf_r <= div_zero;
                        if (div_zero)
                            quot_r <= {sign_in, (SATURATE != 0) ? {M{1'b1}} : {M{1'b0}}};
                    end
                end
                S_CALC: begin
                    // One extra cycle after the last bit packs the result into the output registers.
                    if (last_step) begin
                        ovf_r  <= ovf_calc;
                        quot_r <= {sign, mag_out};
                    end else begin
                        dq  <= {dq[ITER-2:0], q_bit};
                        rem <= rem_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_div_seq.sv
// tb/tb_fxp_div_seq.sv - self-checking bench for fxp_div_seq with scoreboard and vector table
module tb_fxp_div_seq;

    typedef struct {
        logic [19:0] a;
        logic [19:0] b;
        logic [3:0]  tag;
        logic [19:0] q_sat;
        logic [19:0] q_trunc;
        logic        ovf;
        logic        dbz;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_ready;
    logic [19:0] i_dividend, i_divisor;
    logic [3:0]  i_tag;
    logic        o_ready, o_valid, o_overflow, o_div_by_zero, o_busy;
    logic [19:0] o_quotient;
    logic [3:0]  o_tag;
    logic        t_ready, t_valid, t_overflow, t_div_by_zero, t_busy;
    logic [19:0] t_quotient;
    logic [3:0]  t_tag;

    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    fxp_div_seq #(.N(20), .Q(15), .SATURATE(1), .TAG_W(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_quotient(o_quotient), .o_tag(o_tag),
        .o_overflow(o_overflow), .o_div_by_zero(o_div_by_zero), .o_busy(o_busy)
    );

    fxp_div_seq #(.N(20), .Q(15), .SATURATE(0), .TAG_W(4)) dut_trunc (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(t_ready),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .i_tag(i_tag),
        .o_valid(t_valid), .i_ready(i_ready), .o_quotient(t_quotient), .o_tag(t_tag),
        .o_overflow(t_overflow), .o_div_by_zero(t_div_by_zero), .o_busy(t_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [19:0] a, input logic [19:0] b, input logic [3:0] t);
        vec_t v;
        longint unsigned ma, mb, qq;
        logic s;
        ma = 64'(a[18:0]);
        mb = 64'(b[18:0]);
        s  = a[19] ^ b[19];
        v.a = a; v.b = b; v.tag = t;
        if (mb == 0) begin
            v.dbz = 1'b1; v.ovf = 1'b1;
            v.q_sat = {s, 19'h7FFFF};
            v.q_trunc = {s, 19'h00000};
        end else begin
            qq = (ma << 15) / mb;
            v.dbz = 1'b0;
            v.ovf = (qq >> 19) != 0;
            v.q_trunc = {s, qq[18:0]};
            v.q_sat = v.ovf ? {s, 19'h7FFFF} : v.q_trunc;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {31'd0, o_valid}, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("quotient", 32'(o_quotient), 32'(e.q_sat));
                chk("tag", 32'(o_tag), 32'(e.tag));
                chk("overflow", 32'(o_overflow), 32'(e.ovf));
                chk("div_by_zero", 32'(o_div_by_zero), 32'(e.dbz));
                chk("trunc_valid", 32'(t_valid), 32'd1);
                chk("trunc_quotient", 32'(t_quotient), 32'(e.q_trunc));
                chk("trunc_overflow", 32'(t_overflow), 32'(e.ovf));
                chk("trunc_tag_dbz", {t_tag, t_div_by_zero}, {e.tag, e.dbz});
            end
        end
    end

    // Holds the request until accepted; pushes the expectation on the accept edge.
    task automatic do_req(input vec_t v, input bit expect_sb);
        int n;
        i_dividend = v.a; i_divisor = v.b; i_tag = v.tag; i_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ready) begin
            chk("accept_timeout", 32'(n), 32'd0);
            i_valid = 1'b0;
        end else begin
            if (expect_sb) sb.push_back(v);
            @(posedge clk); #1;
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_valid) chk("valid_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int   lat;
        vec_t v;
        logic [19:0] snap_q;
        logic [3:0]  snap_t;

        tbl[0]  = '{20'h18000, 20'h10000, 4'd5, 20'h0C000, 20'h0C000, 1'b0, 1'b0};
        tbl[1]  = '{20'h98000, 20'h10000, 4'd1, 20'h8C000, 20'h8C000, 1'b0, 1'b0};
        tbl[2]  = '{20'h98000, 20'h90000, 4'd2, 20'h0C000, 20'h0C000, 1'b0, 1'b0};
        tbl[3]  = '{20'h40000, 20'h02000, 4'd3, 20'h7FFFF, 20'h00000, 1'b1, 1'b0};
        tbl[4]  = '{20'h08000, 20'h80000, 4'd4, 20'hFFFFF, 20'h80000, 1'b1, 1'b1};
        tbl[5]  = '{20'h00000, 20'h10000, 4'd6, 20'h00000, 20'h00000, 1'b0, 1'b0};
        tbl[6]  = '{20'h80000, 20'h10000, 4'd7, 20'h80000, 20'h80000, 1'b0, 1'b0};
        tbl[7]  = '{20'h08000, 20'h08000, 4'd8, 20'h08000, 20'h08000, 1'b0, 1'b0};
        tbl[8]  = '{20'h00001, 20'h7FFFF, 4'd9, 20'h00000, 20'h00000, 1'b0, 1'b0};
        tbl[9]  = '{20'h7FFFF, 20'h00001, 4'hA, 20'h7FFFF, 20'h78000, 1'b1, 1'b0};
        tbl[10] = '{20'h0C000, 20'h18000, 4'hB, 20'h04000, 20'h04000, 1'b0, 1'b0};
        tbl[11] = '{20'h08000, 20'h18000, 4'hC, 20'h02AAA, 20'h02AAA, 1'b0, 1'b0};
        tbl[12] = '{20'h00001, 20'h80001, 4'hD, 20'h88000, 20'h88000, 1'b0, 1'b0};

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_dividend = '0; i_divisor = '0; i_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_quotient", 32'(o_quotient), 32'd0);
        chk("rst_tag", 32'(o_tag), 32'd0);
        chk("rst_flags", {o_overflow, o_div_by_zero}, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ready", {o_ready, t_ready, t_busy}, 32'b110);
        i_rst = 1'b0;
        @(posedge clk); #1;

        do_req(tbl[0], 1'b1);
        chk("busy_calc", 32'(o_busy), 32'd1);
        wait_valid(lat);
        chk("latency", 32'(lat), 32'd35);
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(o_valid), 32'd0);

        for (int i = 1; i < 13; i++) begin
            do_req(tbl[i], 1'b1);
            if (tbl[i].dbz) chk("dz_latency", 32'(o_valid), 32'd1);
        end

        while (!o_ready) begin @(posedge clk); #1; end
        i_ready = 1'b0;
        v = model(20'h0A000, 20'h04000, 4'hE);
        do_req(v, 1'b1);
        wait_valid(lat);
        snap_q = o_quotient; snap_t = o_tag;
        fork
            do_req(model(20'h10000, 20'h08000, 4'hF), 1'b1);
            begin
                for (int k = 0; k < 10; k++) begin
                    @(posedge clk); #1;
                    chk("bp_hold", {o_valid, o_ready, o_tag, o_quotient},
                        {1'b1, 1'b0, snap_t, snap_q});
                end
                i_ready = 1'b1;
            end
        join

        while (!o_ready) begin @(posedge clk); #1; end
        i_dividend = 20'h18000; i_divisor = 20'h08000; i_tag = 4'h3; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        chk("abort_state", {o_ready, o_valid, o_busy}, 32'b100);
        repeat (40) @(posedge clk);
        #1;
        do_req(model(20'h08000, 20'h08000, 4'h2), 1'b1);
        chk("post_abort_q", 32'(tbl[7].q_sat), 32'h08000);

        for (int r = 0; r < 16; r++) begin
            logic [19:0] ra, rb;
            ra = 20'($urandom);
            rb = 20'($urandom) >> $urandom_range(0, 8);
            do_req(model(ra, rb, 4'($urandom)), 1'b1);
        end

        lat = 0;
        while (sb.size() != 0 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
